// File: rtl/inst_encoder_if.sv
// Handshake and field bundle between the instruction producer, the encoder and the
// instruction-memory writer. The encoder connects through the slave modport.
interface inst_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_fmt;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [63:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [63:0] out_addr;
  logic        err;

  modport slave (
    input  in_valid, in_fmt, opcode, funct3, funct7, rd, rs1, rs2, imm, out_ready,
    output in_ready, out_valid, out_inst, out_addr, err
  );

  modport master (
    output in_valid, in_fmt, opcode, funct3, funct7, rd, rs1, rs2, imm, out_ready,
    input  in_ready, out_valid, out_inst, out_addr, err
  );
endinterface

// File: rtl/inst_encoder.sv
// RISC-V field-bundle encoder with a one-entry output register and address tagging.
// Optional IMM_RANGE_CHECK_EN rejects bundles whose immediate does not fit its format.
module inst_encoder #(
  parameter logic [63:0] BASE_ADDR = 64'd0,
  parameter logic [63:0] ADDR_STEP = 64'd4
) (
  input logic           clk,
  input logic           rst_n,
  inst_encoder_if.slave io_bus
);

  typedef enum logic {StEmpty, StFull} state_e;

  state_e      r_state;
  logic [31:0] r_inst;
  logic [63:0] r_addr;
  logic        r_err;

  logic [31:0] w_enc;
  logic        w_fmt_ok;
  logic        w_imm_ok;
  logic        w_legal;
  logic        w_accept;
  logic        w_out_hs;

  assign io_bus.out_valid = (r_state == StFull);
  assign io_bus.out_inst  = r_inst;
  assign io_bus.out_addr  = r_addr;
  assign io_bus.err       = r_err;
  assign io_bus.in_ready  = !io_bus.out_valid || io_bus.out_ready;

  assign w_accept = io_bus.in_valid && io_bus.in_ready;
  assign w_out_hs = io_bus.out_valid && io_bus.out_ready;
  assign w_fmt_ok = (io_bus.in_fmt <= 3'd5);
  assign w_legal  = w_fmt_ok && w_imm_ok;

  always_comb begin
    w_enc = 32'd0;
    case (io_bus.in_fmt)
      3'd0: w_enc = {io_bus.funct7, io_bus.rs2, io_bus.rs1, io_bus.funct3, io_bus.rd,
                     io_bus.opcode};
      3'd1: w_enc = {io_bus.imm[11:0], io_bus.rs1, io_bus.funct3, io_bus.rd, io_bus.opcode};
      3'd2: w_enc = {io_bus.imm[11:5], io_bus.rs2, io_bus.rs1, io_bus.funct3,
                     io_bus.imm[4:0], io_bus.opcode};
      3'd3: w_enc = {io_bus.imm[12], io_bus.imm[10:5], io_bus.rs2, io_bus.rs1, io_bus.funct3,
                     io_bus.imm[4:1], io_bus.imm[11], io_bus.opcode};
      3'd4: w_enc = {io_bus.imm[31:12], io_bus.rd, io_bus.opcode};
      3'd5: w_enc = {io_bus.imm[20], io_bus.imm[10:1], io_bus.imm[11], io_bus.imm[19:12],
                     io_bus.rd, io_bus.opcode};
      default: w_enc = 32'd0;
    endcase
  end

`ifdef IMM_RANGE_CHECK_EN
  logic signed [63:0] w_imm_s;
  assign w_imm_s = io_bus.imm;

  always_comb begin
    w_imm_ok = 1'b1;
    case (io_bus.in_fmt)
      3'd1, 3'd2: w_imm_ok = (w_imm_s >= -64'sd2048) && (w_imm_s <= 64'sd2047);
      3'd3: w_imm_ok = (w_imm_s >= -64'sd4096) && (w_imm_s <= 64'sd4094) && !io_bus.imm[0];
      3'd4: w_imm_ok = (io_bus.imm[11:0] == 12'd0) &&
                       (io_bus.imm[63:32] == {32{io_bus.imm[31]}});
      3'd5: w_imm_ok = (w_imm_s >= -64'sd1048576) && (w_imm_s <= 64'sd1048574) &&
                       !io_bus.imm[0];
      default: w_imm_ok = 1'b1;
    endcase
  end
`else
  // Upper immediate bits only matter to the range check.
  logic [31:0] w_unused_imm;
  assign w_unused_imm = io_bus.imm[63:32];
  assign w_imm_ok     = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= StEmpty;
      r_inst  <= 32'd0;
      r_addr  <= BASE_ADDR;
      r_err   <= 1'b0;
    end else begin
      r_err <= w_accept && !w_legal;
      if (w_out_hs) begin
        r_addr <= r_addr + ADDR_STEP;
      end
      case (r_state)
        StEmpty: begin
          if (w_accept && w_legal) begin
            r_state <= StFull;
            r_inst  <= w_enc;
          end
        end
        StFull: begin
          // A rejected bundle arriving with the handshake still drains the entry.
          if (io_bus.out_ready) begin
            if (w_accept && w_legal) begin
              r_inst <= w_enc;
            end else begin
              r_state <= StEmpty;
            end
          end
        end
        default: r_state <= StEmpty;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// Directed plus randomized bench for inst_encoder, checked against a cycle-level
// reference model that builds instruction words with shift/mask arithmetic.
module tb_inst_encoder;
  localparam logic [63:0] BASE = 64'd0;
  localparam logic [63:0] STEP = 64'd4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  inst_encoder_if bus ();

  inst_encoder #(
    .BASE_ADDR(BASE),
    .ADDR_STEP(STEP)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io_bus(bus)
  );

  int unsigned n_pass = 0;
  int unsigned n_fail = 0;
  int unsigned n_total = 0;

  logic        m_valid = 1'b0;
  logic [31:0] m_inst = 32'd0;
  logic [63:0] m_addr = BASE;
  logic        m_err = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_enc(input logic [2:0] fmt, input logic [6:0] op,
                                          input logic [2:0] f3, input logic [6:0] f7,
                                          input logic [4:0] rd, input logic [4:0] rs1,
                                          input logic [4:0] rs2, input logic [63:0] imm);
    logic [63:0] base, rdp, rs2p, w;
    base = (64'(rs1) << 15) | (64'(f3) << 12) | 64'(op);
    rdp  = 64'(rd) << 7;
    rs2p = 64'(rs2) << 20;
    case (fmt)
      3'd0: w = (64'(f7) << 25) | rs2p | base | rdp;
      3'd1: w = ((imm & 64'hFFF) << 20) | base | rdp;
      3'd2: w = (((imm >> 5) & 64'h7F) << 25) | rs2p | base | ((imm & 64'h1F) << 7);
      3'd3: w = (((imm >> 12) & 64'h1) << 31) | (((imm >> 5) & 64'h3F) << 25) | rs2p | base |
                (((imm >> 1) & 64'hF) << 8) | (((imm >> 11) & 64'h1) << 7);
      3'd4: w = (imm & 64'hFFFFF000) | rdp | 64'(op);
      3'd5: w = (((imm >> 20) & 64'h1) << 31) | (((imm >> 1) & 64'h3FF) << 21) |
                (((imm >> 11) & 64'h1) << 20) | (imm & 64'hFF000) | rdp | 64'(op);
      default: w = 64'd0;
    endcase
    return w[31:0];
  endfunction

  function automatic logic ref_legal(input logic [2:0] fmt, input logic [63:0] imm);
    longint s;
    s = longint'(imm);
    if (fmt > 3'd5) return 1'b0;
`ifdef IMM_RANGE_CHECK_EN
    case (fmt)
      3'd1, 3'd2: return (s >= -2048) && (s <= 2047);
      3'd3: return (s >= -4096) && (s <= 4094) && (s % 2 == 0);
      3'd4: return (s % 4096 == 0) && (s == longint'(int'(s)));
      3'd5: return (s >= -(64'sd1 << 20)) && (s <= (64'sd1 << 20) - 2) && (s % 2 == 0);
      default: return 1'b1;
    endcase
`else
    return (s == s);
`endif
  endfunction

  task automatic drive(input logic v, input logic [2:0] fmt, input logic [6:0] op,
                       input logic [2:0] f3, input logic [6:0] f7, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [63:0] imm,
                       input logic ordy);
    bus.in_valid  = v;
    bus.in_fmt    = fmt;
    bus.opcode    = op;
    bus.funct3    = f3;
    bus.funct7    = f7;
    bus.rd        = rd;
    bus.rs1       = rs1;
    bus.rs2       = rs2;
    bus.imm       = imm;
    bus.out_ready = ordy;
  endtask

  // One clock: check in_ready mid-cycle, advance the model at the edge, check outputs after.
  task automatic cycle();
    logic rdy, acc, leg, hs;
    #3;
    rdy = !m_valid || bus.out_ready;
    if (rst_n) chk("in_ready", bus.in_ready, rdy);
    @(posedge clk);
    if (!rst_n) begin
      m_valid = 1'b0;
      m_inst  = 32'd0;
      m_addr  = BASE;
      m_err   = 1'b0;
    end else begin
      acc   = bus.in_valid && rdy;
      leg   = ref_legal(bus.in_fmt, bus.imm);
      hs    = m_valid && bus.out_ready;
      m_err = acc && !leg;
      if (hs) m_addr = m_addr + STEP;
      if (acc && leg) begin
        m_valid = 1'b1;
        m_inst  = ref_enc(bus.in_fmt, bus.opcode, bus.funct3, bus.funct7, bus.rd, bus.rs1,
                          bus.rs2, bus.imm);
      end else if (hs) begin
        m_valid = 1'b0;
      end
    end
    #1;
    chk("out_valid", bus.out_valid, m_valid);
    chk("out_inst", bus.out_inst, m_inst);
    chk("out_addr", bus.out_addr, m_addr);
    chk("err", bus.err, m_err);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, 3'd0, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 64'd0, 1'b0);
    cycle();
    cycle();
    rst_n = 1'b1;
  endtask

  function automatic logic [63:0] rand_imm();
    longint v;
    case ($urandom_range(0, 3))
      0: v = longint'({$urandom(), $urandom()});
      1: v = longint'($urandom_range(0, 9999)) - 5000;
      2: v = longint'($urandom_range(0, 1 << 22)) - (1 << 21);
      default: v = longint'(int'($urandom() & 32'hFFFFF000));
    endcase
    return v;
  endfunction

  initial begin
    do_reset();
    chk("rst_valid", bus.out_valid, 64'd0);
    chk("rst_inst", bus.out_inst, 64'd0);
    chk("rst_addr", bus.out_addr, BASE);
    chk("rst_err", bus.err, 64'd0);
    chk("rst_in_ready", bus.in_ready, 64'd1);

    // addi x1, x0, 5
    drive(1'b1, 3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 64'd5, 1'b0);
    cycle();
    chk("i_inst", bus.out_inst, 64'h00500093);
    chk("i_addr", bus.out_addr, BASE);
    chk("i_valid", bus.out_valid, 64'd1);
    drive(1'b0, 3'd0, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 64'd0, 1'b1);
    cycle();
    chk("i_drain_addr", bus.out_addr, BASE + STEP);

    // add x3,x1,x2 then sd x2,8(x1)
    do_reset();
    drive(1'b1, 3'd0, 7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 64'd0, 1'b1);
    cycle();
    chk("r_inst", bus.out_inst, 64'h002081B3);
    chk("r_addr", bus.out_addr, 64'd0);
    drive(1'b1, 3'd2, 7'h23, 3'd3, 7'd0, 5'd0, 5'd1, 5'd2, 64'd8, 1'b1);
    cycle();
    chk("s_inst", bus.out_inst, 64'h0020B423);
    chk("s_addr", bus.out_addr, 64'd4);
    chk("s_valid", bus.out_valid, 64'd1);

    // beq x0,x0,-4 then backpressure
    do_reset();
    drive(1'b1, 3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, -64'sd4, 1'b0);
    cycle();
    chk("b_inst", bus.out_inst, 64'hFE000EE3);
    drive(1'b1, 3'd1, 7'h13, 3'd0, 7'd0, 5'd2, 5'd2, 5'd0, 64'd7, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("bp_in_ready", bus.in_ready, 64'd0);
      chk("bp_inst", bus.out_inst, 64'hFE000EE3);
      chk("bp_addr", bus.out_addr, 64'd0);
    end
    drive(1'b0, 3'd0, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 64'd0, 1'b1);
    cycle();
    chk("bp_release_addr", bus.out_addr, 64'd4);
    chk("bp_release_valid", bus.out_valid, 64'd0);

    // Illegal format
    drive(1'b1, 3'd7, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 64'd0, 1'b1);
    cycle();
    chk("fmt7_err", bus.err, 64'd1);
    chk("fmt7_valid", bus.out_valid, 64'd0);
    drive(1'b0, 3'd0, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 64'd0, 1'b1);
    cycle();
    chk("fmt7_err_pulse", bus.err, 64'd0);

    // I immediate out of range
    drive(1'b1, 3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 64'd4096, 1'b1);
    cycle();
`ifdef IMM_RANGE_CHECK_EN
    chk("imm4096_err", bus.err, 64'd1);
    chk("imm4096_valid", bus.out_valid, 64'd0);
`else
    chk("imm4096_err", bus.err, 64'd0);
    chk("imm4096_inst", bus.out_inst, 64'h00000093);
`endif

    // Reset while full and stalled
    drive(1'b1, 3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 64'd5, 1'b0);
    cycle();
    chk("pre_rst_valid", bus.out_valid, 64'd1);
    rst_n = 1'b0;
    cycle();
    chk("mid_rst_valid", bus.out_valid, 64'd0);
    chk("mid_rst_addr", bus.out_addr, BASE);
    rst_n = 1'b1;
    drive(1'b0, 3'd0, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 64'd0, 1'b0);
    #1;
    chk("post_rst_in_ready", bus.in_ready, 64'd1);
    #0;

    for (int i = 0; i < 500; i++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      drive($urandom_range(0, 9) < 7, 3'($urandom_range(0, 7)), 7'($urandom()),
            3'($urandom()), 7'($urandom()), 5'($urandom()), 5'($urandom()), 5'($urandom()),
            rand_imm(), $urandom_range(0, 9) < 6);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/inst_encoder.md
INST_ENCODER -- requirements
Module: inst_encoder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 64'd0, meaning the address tagged on the first emitted instruction after reset.
REQ-002 SHALL have parameter ADDR_STEP, default 64'd4, meaning the address increment per emitted instruction.
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  meaning a synchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  meaning the field bundle is valid.
REQ-006 SHALL have port in_ready  output  1  meaning the encoder accepts a bundle this cycle.
REQ-007 SHALL have port in_fmt  input  3  meaning the format: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 6/7 illegal.
REQ-008 SHALL have ports opcode (input, 7), funct3 (input, 3), funct7 (input, 7), rd (input, 5), rs1 (input, 5), rs2 (input, 5) and imm (input, 64), meaning the instruction fields, with imm as a sign-extended byte value.
REQ-009 SHALL have port out_valid  output  1  meaning out_inst/out_addr hold an encoded instruction.
REQ-010 SHALL have port out_ready  input  1  meaning the consumer (instruction-memory writer) takes the output.
REQ-011 SHALL have ports out_inst (output, 32) and out_addr (output, 64), meaning the encoded word and its target address.
REQ-012 SHALL have port err  output  1  meaning a one-cycle pulse when a bundle is rejected.

Function
REQ-013 SHALL be a one-entry output register with two states: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-014 SHALL drive in_ready = !out_valid || out_ready, combinationally.
REQ-015 SHALL accept a bundle on in_valid && in_ready; a legal bundle SHALL make out_valid=1 on the next edge (latency 1 cycle).
REQ-016 SHALL transition FULL->EMPTY on out_valid && out_ready with no legal accept that cycle, and EMPTY->FULL on a legal accept.
REQ-017 SHALL, when an output handshake and a legal accept coincide, reload out_inst, keep out_valid=1, and advance the address.
REQ-018 SHALL hold out_inst/out_addr stable while out_valid && !out_ready.
REQ-019 SHALL increment the address counter by ADDR_STEP on every output handshake; the counter SHALL wrap modulo 2^64.
REQ-020 SHALL drive out_addr as the counter value, i.e. the address of the instruction currently presented.
REQ-021 SHALL encode R format as {funct7, rs2, rs1, funct3, rd, opcode}.
REQ-022 SHALL encode I format as {imm[11:0], rs1, funct3, rd, opcode}.
REQ-023 SHALL encode S format as {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
REQ-024 SHALL encode B format as {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
REQ-025 SHALL encode U format as {imm[31:12], rd, opcode}.
REQ-026 SHALL encode J format as {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}.
REQ-027 SHALL, for in_fmt 6 or 7, accept and drop the bundle, pulse err for one cycle, and leave the state, output and counter unchanged.
REQ-028 SHALL pass opcode through unmodified; there is no opcode/format consistency check.

Reset
REQ-029 SHALL, on a clk edge with rst_n=0, set out_valid=0, out_inst=32'd0, out_addr=BASE_ADDR and err=0, and enter EMPTY.
REQ-030 SHALL discard a pending output when reset is asserted mid-operation; in_ready SHALL be 1 in the first cycle after reset.

Configuration
REQ-031 SHALL, with IMM_RANGE_CHECK_EN defined, reject any bundle whose imm is out of range: I/S outside [-2048,2047]; B outside [-4096,4094] or odd; J outside [-2^20,2^20-2] or odd; U if imm[11:0]!=0 or imm[63:32] is not the sign of imm[31]. Rejection SHALL follow the REQ-027 behaviour.
REQ-032 SHALL, without IMM_RANGE_CHECK_EN, silently truncate imm per REQ-022..026; err SHALL then assert only for illegal in_fmt.

Verification
REQ-033 SHALL cover I format: fmt=1, opcode=0x13, funct3=0, rd=1, rs1=0, imm=5 -> out_inst=0x00500093, out_addr=BASE_ADDR, one cycle later.
REQ-034 SHALL cover R then S back-to-back with out_ready=1: add x3,x1,x2 -> 0x002081B3 at addr 0, then sd x2,8(x1) (opcode 0x23, funct3 3) -> 0x0020B423 at addr 4.
REQ-035 SHALL cover B format: fmt=3, opcode=0x63, rs1=rs2=0, funct3=0, imm=-4 -> out_inst=0xFE000EE3.
REQ-036 SHALL cover backpressure: out_ready=0 for 5 cycles while FULL -> in_ready=0 and out_inst/out_addr stable; out_ready=1 -> handshake, address advances by 4.
REQ-037 SHALL cover rejection: fmt=7 -> err pulse, no out_valid. Also I format with imm=4096: with the macro -> err pulse, dropped; without it -> 0x00000093 for rd=1, rs1=0.
REQ-038 SHALL cover reset mid-operation: rst_n=0 while FULL with out_ready=0 -> next cycle out_valid=0 and out_addr=BASE_ADDR.
